fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: program counter and address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 16: instruction memory word width.
REQ-003 SHALL have parameter IMM_FLAG_BIT, default 0: opcode bit which, when 1, marks a following immediate word.
REQ-004 SHALL have parameter RESET_PC, default 0: PC after reset when the vector load is compiled out.
REQ-005 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_stall, input, 1: holds PC, FSM and output registers.
REQ-008 SHALL have port i_flush, input, 1: invalidates the output register without a PC change.
REQ-009 SHALL have port i_branch_decision, input, 1: redirect request.
REQ-010 SHALL have port i_branch_target, input, PC_WIDTH: redirect address.
REQ-011 SHALL have port o_imem_addr, output, PC_WIDTH: asynchronous-read instruction memory address.
REQ-012 SHALL have port i_imem_data, input, INSTR_WIDTH: memory word at o_imem_addr, same cycle.
REQ-013 SHALL have port o_instr, output, INSTR_WIDTH: registered opcode word.
REQ-014 SHALL have port o_imm, output, INSTR_WIDTH: registered immediate word; 0 if none.
REQ-015 SHALL have port o_pc, output, PC_WIDTH: address of the opcode word of o_instr.
REQ-016 SHALL have port o_pc_next, output, PC_WIDTH: address after the instruction, including its immediate (call return address).
REQ-017 SHALL have port o_valid, output, 1: output register holds a live instruction.

Function
REQ-018 SHALL drive o_imem_addr = PC combinationally in every state.
REQ-019 SHALL implement states S_VEC_HI, S_VEC_LO, S_OP, S_IMM.
REQ-020 S_OP, flag bit 0: SHALL load o_instr = word, o_imm = 0, o_pc = PC, o_pc_next = PC+1, o_valid = 1; PC += 1; remain in S_OP.
REQ-021 S_OP, flag bit 1: SHALL latch the opcode and its PC internally, set o_valid = 0, PC += 1, and go to S_IMM.
REQ-022 S_IMM: SHALL load o_instr = latched opcode, o_imm = word, o_pc = latched PC, o_pc_next = PC+1, o_valid = 1; PC += 1; go to S_OP.
REQ-023 SHALL give one-cycle latency from word fetch to the output register.
REQ-024 PC increment SHALL wrap from all-ones to 0.
REQ-025 i_stall SHALL freeze PC, FSM state, the latched opcode and every output register.
REQ-026 i_branch_decision in S_OP or S_IMM SHALL set PC = i_branch_target, state = S_OP and o_valid = 0, discarding any latched opcode.
REQ-027 Priority SHALL be: reset > branch > stall > flush > normal fetch.
REQ-028 i_flush without branch or stall SHALL clear o_valid and SHALL still advance PC and state normally.
REQ-029 i_branch_decision in S_VEC_HI or S_VEC_LO SHALL be ignored.

Reset
REQ-030 On i_reset, o_instr, o_imm, o_pc, o_pc_next and o_valid SHALL be 0.
REQ-031 On i_reset, the latched opcode SHALL be 0.
REQ-032 With the vector load compiled in, reset SHALL set PC = 0 and state = S_VEC_HI.
REQ-033 With the vector load compiled out, reset SHALL set PC = RESET_PC and state = S_OP.
REQ-034 Reset asserted mid-operation SHALL abandon any pending immediate.

Configuration
REQ-035 Macro FETCH_RESET_VECTOR_EN defined: S_VEC_HI SHALL capture word[0] as PC high half and set PC = 1; S_VEC_LO SHALL then set PC = {high, word[1]} and go to S_OP; o_valid SHALL stay 0 throughout, and i_stall SHALL be honoured.
REQ-036 Macro FETCH_RESET_VECTOR_EN undefined: the vector states SHALL be unreachable.

Structure
REQ-037 Shared package fetch_pkg SHALL hold the FSM state typedef and the width defaults.
REQ-038 Output register slice SHALL be the sub-module if_id_reg, with stall-hold and flush-clear.

Verification
REQ-039 Vector load: mem[0]=0x0000, mem[1]=0x0040 -> first o_valid with o_pc=0x40, 3 cycles after reset release.
REQ-040 Immediate fetch: opcode 0x1235 at 0x40, imm 0xBEEF at 0x41 -> single o_valid pulse with o_instr=0x1235, o_imm=0xBEEF, o_pc=0x40, o_pc_next=0x42.
REQ-041 Branch wins: stall and branch to 0x80 asserted together -> next cycle o_valid=0 and o_imem_addr=0x80.
REQ-042 Stall: 3 stall cycles during S_IMM -> outputs and o_imem_addr constant; fetch resumes without loss.
REQ-043 Wrap: PC 0xFFFFFFFF with a one-word opcode -> o_pc_next=0, next o_imem_addr=0.
REQ-044 Reset mid-immediate: i_reset asserted in S_IMM -> all outputs 0 asynchronously; vector load restarts.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg -- shared definitions for the instruction fetch unit.
//
// Holds the fetch FSM state type, the default widths used by fetch_unit and
// if_id_reg, and a small helper that tells whether a state is fetching
// instructions (as opposed to loading the reset vector).
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned FETCH_PC_WIDTH     = 32;
   localparam int unsigned FETCH_INSTR_WIDTH  = 16;
   localparam int unsigned FETCH_IMM_FLAG_BIT = 0;

   typedef enum logic [1:0] {
      S_VEC_HI = 2'd0,   // reading high half of the reset vector
      S_VEC_LO = 2'd1,   // reading low half of the reset vector
      S_OP     = 2'd2,   // fetching an opcode word
      S_IMM    = 2'd3    // fetching the immediate of a latched opcode
   } fetch_state_e;

   // True in the states where a branch redirect is honoured.
   function automatic logic is_fetch_state(input fetch_state_e st);
      return (st == S_OP) || (st == S_IMM);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg -- fetch output register slice.
//
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (clears everything)
//   i_stall          hold every register
//   i_flush          clear o_valid only (data registers keep their value)
//   i_load           a complete instruction is presented this cycle
//   i_instr, i_imm   opcode word and immediate word (0 when none)
//   i_pc, i_pc_next  opcode address and the address after the instruction
//   o_*              registered copies; o_valid marks a live instruction
//
// Priority inside the slice: reset > stall > flush > load.
// -----------------------------------------------------------------------------
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = FETCH_PC_WIDTH,
   parameter int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_stall,
   input  logic                   i_flush,
   input  logic                   i_load,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   input  logic [INSTR_WIDTH-1:0] i_imm,
   input  logic [PC_WIDTH-1:0]    i_pc,
   input  logic [PC_WIDTH-1:0]    i_pc_next,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [INSTR_WIDTH-1:0] o_imm,
   output logic [PC_WIDTH-1:0]    o_pc,
   output logic [PC_WIDTH-1:0]    o_pc_next,
   output logic                   o_valid
);

   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [INSTR_WIDTH-1:0] imm_q, imm_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [PC_WIDTH-1:0]    pc_next_q, pc_next_d;
   logic                   valid_q, valid_d;

   // Next-state selection: hold, flush, load or go idle.
   always_comb begin
      instr_d   = instr_q;
      imm_d     = imm_q;
      pc_d      = pc_q;
      pc_next_d = pc_next_q;
      valid_d   = valid_q;
      if (i_stall) begin
         valid_d = valid_q;
      end else if (i_flush) begin
         valid_d = 1'b0;
      end else if (i_load) begin
         instr_d   = i_instr;
         imm_d     = i_imm;
         pc_d      = i_pc;
         pc_next_d = i_pc_next;
         valid_d   = 1'b1;
      end else begin
         valid_d = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         instr_q   <= '0;
         imm_q     <= '0;
         pc_q      <= '0;
         pc_next_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         instr_q   <= instr_d;
         imm_q     <= imm_d;
         pc_q      <= pc_d;
         pc_next_q <= pc_next_d;
         valid_q   <= valid_d;
      end
   end

   assign o_instr   = instr_q;
   assign o_imm     = imm_q;
   assign o_pc      = pc_q;
   assign o_pc_next = pc_next_q;
   assign o_valid   = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch with optional immediate word.
//
// Reads one word per cycle from an asynchronous-read instruction memory at
// o_imem_addr (= PC). An opcode whose bit IMM_FLAG_BIT is set is followed by
// one immediate word; the pair is presented together one cycle after the
// immediate is read. One-word opcodes are presented one cycle after fetch.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_stall                freeze PC, FSM, latched opcode and outputs
//   i_flush                drop the output instruction; fetch keeps going
//   i_branch_decision      redirect PC to i_branch_target (beats stall)
//   i_branch_target        redirect address
//   o_imem_addr            instruction memory address (current PC)
//   i_imem_data            memory word at o_imem_addr, same cycle
//   o_instr, o_imm         opcode word and immediate word (0 when none)
//   o_pc, o_pc_next        opcode address and return address after it
//   o_valid                output register holds a live instruction
//
// Build option: define FETCH_RESET_VECTOR_EN to start after reset by reading
// a two-word reset vector from addresses 0 (high half) and 1 (low half).
// Without it the unit starts at RESET_PC directly in S_OP. The vector is
// assembled as {word0, word1}; PC_WIDTH is expected to be at most
// 2*INSTR_WIDTH.
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned          PC_WIDTH     = FETCH_PC_WIDTH,
   parameter int unsigned          INSTR_WIDTH  = FETCH_INSTR_WIDTH,
   parameter int unsigned          IMM_FLAG_BIT = FETCH_IMM_FLAG_BIT,
   parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_stall,
   input  logic                   i_flush,
   input  logic                   i_branch_decision,
   input  logic [PC_WIDTH-1:0]    i_branch_target,
   output logic [PC_WIDTH-1:0]    o_imem_addr,
   input  logic [INSTR_WIDTH-1:0] i_imem_data,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [INSTR_WIDTH-1:0] o_imm,
   output logic [PC_WIDTH-1:0]    o_pc,
   output logic [PC_WIDTH-1:0]    o_pc_next,
   output logic                   o_valid
);

   fetch_state_e           state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] lat_op_q, lat_op_d;
   logic [PC_WIDTH-1:0]    lat_pc_q, lat_pc_d;

   logic                   branch_take_s;
   logic [PC_WIDTH-1:0]    pc_inc_s;
   logic                   load_s;
   logic [INSTR_WIDTH-1:0] ld_instr_s;
   logic [INSTR_WIDTH-1:0] ld_imm_s;
   logic [PC_WIDTH-1:0]    ld_pc_s;
   logic [PC_WIDTH-1:0]    ld_pc_next_s;

`ifdef FETCH_RESET_VECTOR_EN
   localparam int unsigned VEC_WIDTH = 2 * INSTR_WIDTH;
   logic [INSTR_WIDTH-1:0] vec_hi_q, vec_hi_d;
   logic [VEC_WIDTH-1:0]   vec_full_s;
   assign vec_full_s = {vec_hi_q, i_imem_data};
`endif

   assign o_imem_addr = pc_q;
   // Natural wrap from all-ones to zero.
   assign pc_inc_s = pc_q + PC_WIDTH'(1);
   // Branches are ignored while the reset vector is being loaded.
   assign branch_take_s = i_branch_decision & is_fetch_state(state_q);

   // Next-state logic for PC, FSM, latched opcode and output-slice load data.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      lat_op_d     = lat_op_q;
      lat_pc_d     = lat_pc_q;
      load_s       = 1'b0;
      ld_instr_s   = '0;
      ld_imm_s     = '0;
      ld_pc_s      = '0;
      ld_pc_next_s = '0;
`ifdef FETCH_RESET_VECTOR_EN
      vec_hi_d     = vec_hi_q;
`endif
      if (branch_take_s) begin
         pc_d     = i_branch_target;
         state_d  = S_OP;
         lat_op_d = '0;
         lat_pc_d = '0;
      end else if (i_stall) begin
         state_d = state_q;
      end else begin
         case (state_q)
`ifdef FETCH_RESET_VECTOR_EN
            S_VEC_HI: begin
               vec_hi_d = i_imem_data;
               pc_d     = PC_WIDTH'(1);
               state_d  = S_VEC_LO;
            end
            S_VEC_LO: begin
               pc_d    = PC_WIDTH'(vec_full_s);
               state_d = S_OP;
            end
`else
            S_VEC_HI: state_d = S_OP;
            S_VEC_LO: state_d = S_OP;
`endif
            S_OP: begin
               pc_d = pc_inc_s;
               if (i_imem_data[IMM_FLAG_BIT]) begin
                  lat_op_d = i_imem_data;
                  lat_pc_d = pc_q;
                  state_d  = S_IMM;
               end else begin
                  load_s       = 1'b1;
                  ld_instr_s   = i_imem_data;
                  ld_imm_s     = '0;
                  ld_pc_s      = pc_q;
                  ld_pc_next_s = pc_inc_s;
                  state_d      = S_OP;
               end
            end
            S_IMM: begin
               load_s       = 1'b1;
               ld_instr_s   = lat_op_q;
               ld_imm_s     = i_imem_data;
               ld_pc_s      = lat_pc_q;
               ld_pc_next_s = pc_inc_s;
               pc_d         = pc_inc_s;
               state_d      = S_OP;
            end
            default: state_d = S_OP;
         endcase
      end
   end

   // Fetch state registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
`ifdef FETCH_RESET_VECTOR_EN
         state_q  <= S_VEC_HI;
         pc_q     <= '0;
         vec_hi_q <= '0;
`else
         state_q  <= S_OP;
         pc_q     <= RESET_PC;
`endif
         lat_op_q <= '0;
         lat_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         lat_op_q <= lat_op_d;
         lat_pc_q <= lat_pc_d;
`ifdef FETCH_RESET_VECTOR_EN
         vec_hi_q <= vec_hi_d;
`endif
      end
   end

   // A taken branch overrides stall and invalidates the output, so it is
   // folded into the slice's stall/flush controls here.
   if_id_reg #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_if_id_reg (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_stall   (i_stall & ~branch_take_s),
      .i_flush   (i_flush | branch_take_s),
      .i_load    (load_s),
      .i_instr   (ld_instr_s),
      .i_imm     (ld_imm_s),
      .i_pc      (ld_pc_s),
      .i_pc_next (ld_pc_next_s),
      .o_instr   (o_instr),
      .o_imm     (o_imm),
      .o_pc      (o_pc),
      .o_pc_next (o_pc_next),
      .o_valid   (o_valid)
   );

endmodule
